note_sequencer: RTL and testbench

//   Producer side of the expected-note stream consumed by the gameplay scorer.

---
 rtl/note_sequencer_pkg.sv | 39 +++
 rtl/note_sequencer_chart_rom.sv | 32 +++
 rtl/note_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_note_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// note_sequencer_pkg
//   Shared definitions for the expected-note sequencer: chord width, the
//   "no note due" value, the one-hot FSM state encoding and small state
//   classification helpers used by the sequencer.
// -----------------------------------------------------------------------------
package note_sequencer_pkg;

    // Five frets, one bit per fret.
    localparam int unsigned NOTE_W = 5;

    typedef logic [NOTE_W-1:0] notes_t;

    // Chart sentinel and the value driven on exp_notes when nothing is due.
    localparam notes_t NO_NOTES = '0;

    // One-hot state encoding: a single bit per state keeps the busy /
    // song_done decodes to one OR gate each.
    typedef enum logic [5:0] {
        ST_IDLE       = 6'b000001,
        ST_FETCH      = 6'b000010,
        ST_FETCH_WAIT = 6'b000100,
        ST_GAP        = 6'b001000,
        ST_WINDOW     = 6'b010000,
        ST_DONE       = 6'b100000
    } state_e;

    // States in which a song is in progress.
    function automatic logic is_busy(input state_e s);
        return (s == ST_FETCH) || (s == ST_FETCH_WAIT) ||
               (s == ST_GAP)   || (s == ST_WINDOW);
    endfunction

    // States whose duration is measured in chart ticks.
    function automatic logic is_timed(input state_e s);
        return (s == ST_GAP) || (s == ST_WINDOW);
    endfunction

endpackage : note_sequencer_pkg

// File: rtl/note_sequencer_chart_rom.sv
// -----------------------------------------------------------------------------
// note_sequencer_chart_rom
//   Song chart ROM with a synchronous read port (one cycle of latency).
//   Contents come from the CHART_INIT parameter: entry i occupies bits
//   [i*DATA_W +: DATA_W], each entry formatted as {notes, gap}.
// Ports
//   clk_i   in  1       clock
//   addr_i  in  ADDR_W  entry address, sampled every cycle
//   data_o  out DATA_W  entry at the address presented on the previous cycle
// -----------------------------------------------------------------------------
module note_sequencer_chart_rom #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 13,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] CHART_INIT = '0
) (
    input  logic              clk_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    // NOTE: ROM/RAM read registers get no reset so they map onto block
    // memory output registers; the sequencer never consumes this value
    // before a FETCH has presented a valid address.
    always_ff @(posedge clk_i) begin
        data_q <= CHART_INIT[addr_i*DATA_W +: DATA_W];
    end

    assign data_o = data_q;

endmodule : note_sequencer_chart_rom

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
//   Producer of the expected-note stream for the gameplay scorer. Walks the
//   song chart, holds each chord on exp_notes for a fixed hit window and
//   always puts a silent gap (exp_notes == 0) in front of every chord.
// Ports
//   CLOCK_50    in   1       system clock
//   resetn      in   1       asynchronous active-low reset
//   start       in   1       level; starts the song from entry 0 in IDLE/DONE
//   pause       in   1       level; freezes tick timing while high
//   exp_notes   out  5       expected chord, one bit per fret; 0 = none due
//   note_valid  out  1       one-cycle pulse when exp_notes becomes nonzero
//   busy        out  1       song in progress (FETCH/FETCH_WAIT/GAP/WINDOW)
//   song_done   out  1       held high in DONE
//   note_index  out  ADDR_W  address of the current chart entry
// -----------------------------------------------------------------------------
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 2_500_000,
    parameter int unsigned WINDOW_TICKS = 6,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned GAP_W        = 8,
    parameter logic [(2**ADDR_W)*(NOTE_W+GAP_W)-1:0] CHART_INIT = '0
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic              start,
    input  logic              pause,
    output logic [NOTE_W-1:0] exp_notes,
    output logic              note_valid,
    output logic              busy,
    output logic              song_done,
    output logic [ADDR_W-1:0] note_index
);

    localparam int unsigned ENTRY_W = NOTE_W + GAP_W;
    localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned WIN_W   = $clog2(WINDOW_TICKS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
    localparam logic [GAP_W-1:0]  GAP_ONE    = GAP_W'(1);
    localparam logic [WIN_W-1:0]  WIN_ONE    = WIN_W'(1);
    localparam logic [WIN_W-1:0]  WIN_LOAD   = WIN_W'(WINDOW_TICKS);
    localparam logic [ADDR_W-1:0] INDEX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e              state_q,    state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
    logic [WIN_W-1:0]    win_cnt_q,  win_cnt_d;
    notes_t              notes_q,    notes_d;    // chord waiting behind the gap
    notes_t              exp_q,      exp_d;
    logic                valid_q,    valid_d;
    logic [ADDR_W-1:0]   index_q,    index_d;

    // ------------------------------------------------------------------
    // Chart ROM
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]  rom_data;
    notes_t              rom_notes;
    logic [GAP_W-1:0]    rom_gap;

    note_sequencer_chart_rom #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (ENTRY_W),
        .CHART_INIT (CHART_INIT)
    ) u_chart_rom (
        .clk_i  (CLOCK_50),
        .addr_i (index_q),
        .data_o (rom_data)
    );

    assign rom_notes = rom_data[ENTRY_W-1 -: NOTE_W];
    assign rom_gap   = rom_data[GAP_W-1:0];

    // ------------------------------------------------------------------
    // Tick generation: only runs in GAP/WINDOW and only while unpaused,
    // so a paused song resumes with exactly the cycles it had left.
    // ------------------------------------------------------------------
    logic run_timer;
    logic tick;

    assign run_timer = is_timed(state_q) && !pause;
    assign tick      = run_timer && (tick_cnt_q == TICK_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        win_cnt_d  = win_cnt_q;
        notes_d    = notes_q;
        exp_d      = exp_q;
        valid_d    = 1'b0;
        index_d    = index_q;

        if (run_timer) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_ONE;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    index_d = '0;
                end
            end

            // The ROM samples index_q at the end of this cycle.
            ST_FETCH: begin
                state_d = ST_FETCH_WAIT;
            end

            ST_FETCH_WAIT: begin
                if (rom_notes == NO_NOTES) begin
                    state_d = ST_DONE;
                end else begin
                    notes_d    = rom_notes;
                    // A zero gap still gets one silent tick so the scorer
                    // sees every chord begin and end.
                    gap_cnt_d  = (rom_gap == '0) ? GAP_ONE : rom_gap;
                    tick_cnt_d = '0;
                    state_d    = ST_GAP;
                end
            end

            ST_GAP: begin
                if (tick) begin
                    gap_cnt_d = gap_cnt_q - GAP_ONE;
                    if (gap_cnt_q == GAP_ONE) begin
                        state_d   = ST_WINDOW;
                        exp_d     = notes_q;
                        valid_d   = 1'b1;
                        win_cnt_d = WIN_LOAD;
                    end
                end
            end

            ST_WINDOW: begin
                if (tick) begin
                    win_cnt_d = win_cnt_q - WIN_ONE;
                    if (win_cnt_q == WIN_ONE) begin
                        exp_d = NO_NOTES;
                        // A full chart stops on its last entry rather than
                        // wrapping back to entry 0.
                        if (index_q == LAST_INDEX) begin
                            state_d = ST_DONE;
                        end else begin
                            index_d = index_q + INDEX_ONE;
                            state_d = ST_FETCH;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge, regardless of order.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            gap_cnt_q  <= '0;
            win_cnt_q  <= '0;
            notes_q    <= NO_NOTES;
            exp_q      <= NO_NOTES;
            valid_q    <= 1'b0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            win_cnt_q  <= win_cnt_d;
            notes_q    <= notes_d;
            exp_q      <= exp_d;
            valid_q    <= valid_d;
            index_q    <= index_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign exp_notes  = exp_q;
    assign note_valid = valid_q;
    assign busy       = is_busy(state_q);
    assign song_done  = (state_q == ST_DONE);
    assign note_index = index_q;

endmodule : note_sequencer

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
//   Three sequencers with different charts share clock, reset, start and
//   pause. A per-instance reference model expands each chart into the
//   timeline of outputs an unpaused song produces, then walks it one step per
//   clock, standing still on gap/window steps while pause is high.
// -----------------------------------------------------------------------------
module tb_note_sequencer;

    localparam int TD      = 4;   // clock cycles per tick
    localparam int WIN     = 2;   // ticks per hit window
    localparam int ADDR_W  = 2;
    localparam int GAP_W   = 8;
    localparam int ENTRY_W = 5 + GAP_W;
    localparam int CHART_W = 4 * ENTRY_W;
    localparam int NDUT    = 3;
    localparam int MAXLEN  = 128;

    // Entries listed from entry 3 down to entry 0, each {notes, gap}.
    // A: two chords then sentinel (entry 3 must never play).
    localparam logic [CHART_W-1:0] CHART_A =
        {5'b00100, 8'd1, 5'b00000, 8'd0, 5'b10010, 8'd0, 5'b00001, 8'd2};
    // B: four chords, no sentinel.
    localparam logic [CHART_W-1:0] CHART_B =
        {5'b10101, 8'd2, 5'b11000, 8'd3, 5'b00110, 8'd0, 5'b00001, 8'd1};
    // C: sentinel at entry 0.
    localparam logic [CHART_W-1:0] CHART_C =
        {5'b01000, 8'd1, 5'b00010, 8'd2, 5'b00001, 8'd1, 5'b00000, 8'd5};

    typedef struct packed {
        logic [4:0] notes;
        logic       nv;
        logic       busy;
        logic       done;
        logic [1:0] idx;
        logic       pausable;
        logic       rest;
    } step_t;

    logic clk = 1'b0;
    logic resetn, start, pause;
    logic [4:0]        exp_o  [NDUT];
    logic              nv_o   [NDUT];
    logic              busy_o [NDUT];
    logic              done_o [NDUT];
    logic [ADDR_W-1:0] idx_o  [NDUT];

    int checks   = 0;
    int failures = 0;

    step_t tl [NDUT][MAXLEN];
    int    tl_len  [NDUT];
    int    pos     [NDUT];
    bit    arrived [NDUT];
    int    nv_cnt  [NDUT];
    bit    seen_nz [NDUT];

    always #5 clk = ~clk;

    note_sequencer #(.TICK_DIV(TD), .WINDOW_TICKS(WIN), .ADDR_W(ADDR_W),
                     .GAP_W(GAP_W), .CHART_INIT(CHART_A)) dut_a (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .pause(pause),
        .exp_notes(exp_o[0]), .note_valid(nv_o[0]), .busy(busy_o[0]),
        .song_done(done_o[0]), .note_index(idx_o[0]));

    note_sequencer #(.TICK_DIV(TD), .WINDOW_TICKS(WIN), .ADDR_W(ADDR_W),
                     .GAP_W(GAP_W), .CHART_INIT(CHART_B)) dut_b (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .pause(pause),
        .exp_notes(exp_o[1]), .note_valid(nv_o[1]), .busy(busy_o[1]),
        .song_done(done_o[1]), .note_index(idx_o[1]));

    note_sequencer #(.TICK_DIV(TD), .WINDOW_TICKS(WIN), .ADDR_W(ADDR_W),
                     .GAP_W(GAP_W), .CHART_INIT(CHART_C)) dut_c (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .pause(pause),
        .exp_notes(exp_o[2]), .note_valid(nv_o[2]), .busy(busy_o[2]),
        .song_done(done_o[2]), .note_index(idx_o[2]));

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic string dut_name(input int k);
        return (k == 0) ? "A" : (k == 1) ? "B" : "C";
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic step_t mk(input logic [4:0] n, input logic v, input logic b,
                                 input logic d, input logic [1:0] i,
                                 input logic p, input logic r);
        step_t s;
        s.notes = n; s.nv = v; s.busy = b; s.done = d;
        s.idx = i; s.pausable = p; s.rest = r;
        return s;
    endfunction

    task automatic push(input int k, input step_t s);
        tl[k][tl_len[k]] = s;
        tl_len[k] = tl_len[k] + 1;
    endtask

    // Expand a chart into the per-cycle outputs of an unpaused play-through:
    // two fetch cycles per entry, gap ticks of silence, window ticks of chord.
    task automatic build(input int k, input logic [CHART_W-1:0] chart);
        logic [ENTRY_W-1:0] e;
        int g;
        bit ended;
        ended = 1'b0;
        tl_len[k] = 0;
        for (int i = 0; i < 4; i++) begin
            if (!ended) begin
                e = chart[i*ENTRY_W +: ENTRY_W];
                push(k, mk(5'd0, 1'b0, 1'b1, 1'b0, 2'(i), 1'b0, 1'b0));
                push(k, mk(5'd0, 1'b0, 1'b1, 1'b0, 2'(i), 1'b0, 1'b0));
                if (e[ENTRY_W-1 -: 5] == 5'd0) begin
                    push(k, mk(5'd0, 1'b0, 1'b0, 1'b1, 2'(i), 1'b0, 1'b1));
                    ended = 1'b1;
                end else begin
                    g = (e[GAP_W-1:0] == '0) ? 1 : int'(e[GAP_W-1:0]);
                    for (int c = 0; c < g * TD; c++)
                        push(k, mk(5'd0, 1'b0, 1'b1, 1'b0, 2'(i), 1'b1, 1'b0));
                    for (int c = 0; c < WIN * TD; c++)
                        push(k, mk(e[ENTRY_W-1 -: 5], (c == 0), 1'b1, 1'b0, 2'(i), 1'b1, 1'b0));
                end
            end
        end
        if (!ended) push(k, mk(5'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1));
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            pos[k] = -1;
            arrived[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            if (!resetn) begin
                pos[k] = -1;
                arrived[k] = 1'b0;
            end else if (pos[k] < 0 || tl[k][pos[k]].rest) begin
                if (start) begin
                    pos[k] = 0;
                    arrived[k] = 1'b1;
                end else begin
                    arrived[k] = 1'b0;
                end
            end else if (pause && tl[k][pos[k]].pausable) begin
                arrived[k] = 1'b0;
            end else begin
                pos[k] = pos[k] + 1;
                arrived[k] = 1'b1;
            end
        end
    endtask

    function automatic logic [9:0] want(input int k);
        step_t s;
        if (pos[k] < 0) return 10'd0;
        s = tl[k][pos[k]];
        return {s.notes, s.nv & arrived[k], s.busy, s.done, s.idx};
    endfunction

    function automatic logic [9:0] observed(input int k);
        return {exp_o[k], nv_o[k], busy_o[k], done_o[k], idx_o[k]};
    endfunction

    task automatic compare_all(input string tag);
        for (int k = 0; k < NDUT; k++)
            check({tag, "_", dut_name(k)}, 16'(observed(k)), 16'(want(k)));
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all("cyc");
        for (int k = 0; k < NDUT; k++) begin
            if (nv_o[k]) nv_cnt[k]++;
            if (exp_o[k] != 5'd0) seen_nz[k] = 1'b1;
        end
    endtask

    // Called 1 time unit after an edge: asserts reset mid-cycle.
    task automatic do_reset();
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        for (int k = 0; k < NDUT; k++) begin
            check({"rst_exp_", dut_name(k)}, 16'(exp_o[k]), 16'd0);
            check({"rst_busy_", dut_name(k)}, 16'(busy_o[k]), 16'd0);
        end
        cycle();
        #3;
        resetn = 1'b1;
    endtask

    task automatic wait_chord_a(input string tag);
        int n;
        n = 0;
        while (exp_o[0] == 5'd0 && n < 60) begin
            cycle();
            n++;
        end
        check(tag, 16'(exp_o[0] != 5'd0), 16'd1);
    endtask

    task automatic clear_stats();
        for (int k = 0; k < NDUT; k++) nv_cnt[k] = 0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int win_len;
        int n;
        int viol;
        int restarts;
        logic [ADDR_W-1:0] prev_idx;
        logic prev_busy, prev_done;

        resetn = 1'b0;
        start  = 1'b0;
        pause  = 1'b0;
        build(0, CHART_A);
        build(1, CHART_B);
        build(2, CHART_C);
        model_reset();
        for (int k = 0; k < NDUT; k++) seen_nz[k] = 1'b0;
        clear_stats();

        #2;
        compare_all("reset");
        repeat (2) cycle();
        #3 resetn = 1'b1;
        repeat (3) cycle();

        // Single start pulse, full play-through of each chart.
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (80) cycle();
        check("song_nv_A", 16'(nv_cnt[0]), 16'd2);
        check("song_nv_B", 16'(nv_cnt[1]), 16'd4);
        check("song_nv_C", 16'(nv_cnt[2]), 16'd0);
        check("song_done_A", 16'(done_o[0]), 16'd1);
        check("song_idx_A", 16'(idx_o[0]), 16'd2);
        check("song_done_B", 16'(done_o[1]), 16'd1);
        check("song_idx_B", 16'(idx_o[1]), 16'd3);

        // Pause for 20 cycles inside A's first window.
        clear_stats();
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_chord_a("pause_chord_seen");
        win_len = 1;
        repeat (2) begin
            cycle();
            if (exp_o[0] == 5'b00001) win_len++;
        end
        pause = 1'b1;
        repeat (20) begin
            cycle();
            if (exp_o[0] == 5'b00001) win_len++;
        end
        pause = 1'b0;
        n = 0;
        while (exp_o[0] != 5'd0 && n < 40) begin
            cycle();
            if (exp_o[0] == 5'b00001) win_len++;
            n++;
        end
        check("pause_window_len", 16'(win_len), 16'd28);
        repeat (60) cycle();
        check("pause_nv_A", 16'(nv_cnt[0]), 16'd2);

        // Asynchronous reset in the middle of A's window.
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_chord_a("reset_chord_seen");
        repeat (2) cycle();
        do_reset();
        repeat (3) cycle();
        check("post_reset_busy_A", 16'(busy_o[0]), 16'd0);
        check("post_reset_idx_A", 16'(idx_o[0]), 16'd0);

        // start held high: ignored while busy, restarts from DONE.
        start = 1'b1;
        viol = 0;
        restarts = 0;
        prev_idx = '0;
        prev_busy = 1'b0;
        prev_done = 1'b0;
        repeat (160) begin
            cycle();
            if (busy_o[0] && prev_busy && (idx_o[0] < prev_idx)) viol++;
            if (prev_done && busy_o[0]) begin
                restarts++;
                check("restart_idx_A", 16'(idx_o[0]), 16'd0);
            end
            prev_idx  = idx_o[0];
            prev_busy = busy_o[0];
            prev_done = done_o[0];
        end
        start = 1'b0;
        check("held_start_monotonic", 16'(viol), 16'd0);
        check("held_start_restarted", 16'(restarts > 0), 16'd1);
        repeat (80) cycle();

        // Randomized start / pause with occasional mid-cycle reset.
        repeat (3000) begin
            cycle();
            start = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        check("sentinel_never_plays_C", 16'(seen_nz[2]), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_note_sequencer
